vxe_skid_buf: RTL and testbench

Two-entry valid/ready skid buffer that decouples a producing pipeline stage from a consuming register stage in the VxEngine datapath. It accepts words from upstream under a valid/ready handshake and presents them in order to a downstream consumer. It also provides a write-enable strobe that loads a downstream parameterized register directly. Upstream ready is fully registered, so the ready path is broken between stages at no bandwidth cost.

---
 rtl/vxe_skid_buf.sv | 96 +++++++++
 tb/tb_vxe_skid_buf.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/vxe_skid_buf.sv
// Two-entry valid/ready skid buffer with registered upstream ready and a downstream write-enable strobe.
// Optional synchronous flush port is built when VXE_SKID_BUF_FLUSH_EN is defined.
module vxe_skid_buf #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  i_rdy,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    input  logic                  o_rdy,
    output logic                  o_wr_en,
    output logic                  o_full
`ifdef VXE_SKID_BUF_FLUSH_EN
    ,
    input  logic                  flush
`endif
);

    // state    | meaning
    // ST_EMPTY | no word held
    // ST_ONE   | main entry holds the oldest word
    // ST_FULL  | main and skid entries both hold words; upstream stalled
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] main_q, main_d;
    logic [DATA_WIDTH-1:0] skid_q, skid_d;
    logic                  push;
    logic                  pop;

    assign i_rdy   = (state_q != ST_FULL);
    assign o_valid = (state_q != ST_EMPTY);
    assign o_full  = (state_q == ST_FULL);
    assign o_data  = main_q;
    assign o_wr_en = o_valid & o_rdy;

    assign push = i_valid & i_rdy;
    assign pop  = o_valid & o_rdy;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (push) begin
                    state_d = ST_ONE;
                    main_d  = i_data;
                end
            end
            ST_ONE: begin
                if (push && pop) begin
                    main_d = i_data;
                end else if (push) begin
                    state_d = ST_FULL;
                    skid_d  = i_data;
                end else if (pop) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (pop) begin
                    state_d = ST_ONE;
                    main_d  = skid_q;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
`ifdef VXE_SKID_BUF_FLUSH_EN
        // A pop in the flush cycle still completes downstream; everything else is dropped.
        if (flush) begin
            state_d = ST_EMPTY;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

endmodule

// File: tb/tb_vxe_skid_buf.sv
// Scoreboard bench for vxe_skid_buf: words are queued on accepted pushes and checked on o_wr_en.
// The queue depth also serves as the occupancy model for i_rdy / o_valid / o_full / o_wr_en.
module tb_vxe_skid_buf;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          nrst = 1'b0;
    logic          i_valid = 1'b0;
    logic [DW-1:0] i_data = '0;
    logic          i_rdy;
    logic          o_valid;
    logic [DW-1:0] o_data;
    logic          o_rdy = 1'b0;
    logic          o_wr_en;
    logic          o_full;
    logic          flush = 1'b0;

    int n_vec = 0;
    int n_err = 0;
    int n_wr  = 0;
    logic [DW-1:0] sb_q[$];

    vxe_skid_buf #(.DATA_WIDTH(DW)) dut (
        .clk     (clk),
        .nrst    (nrst),
        .i_valid (i_valid),
        .i_data  (i_data),
        .i_rdy   (i_rdy),
        .o_valid (o_valid),
        .o_data  (o_data),
        .o_rdy   (o_rdy),
        .o_wr_en (o_wr_en),
        .o_full  (o_full)
`ifdef VXE_SKID_BUF_FLUSH_EN
        ,
        .flush   (flush)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Monitor on the falling edge: check outputs against the model, then apply what the next posedge will do.
    always @(negedge clk) begin
        int occ;
        occ = sb_q.size();
        chk("o_valid", o_valid, occ != 0);
        chk("i_rdy",   i_rdy,   occ < 2);
        chk("o_full",  o_full,  occ == 2);
        chk("o_wr_en", o_wr_en, (occ != 0) && o_rdy);
        if (occ != 0) chk("o_data", o_data, sb_q[0]);
        if (!nrst) begin
            sb_q.delete();
        end else begin
            if (o_wr_en) begin
                n_wr++;
                if (occ == 0) chk("pop_empty", 1, 0);
                else void'(sb_q.pop_front());
            end
            if (flush) sb_q.delete();
            else if (i_valid && i_rdy) sb_q.push_back(i_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [DW-1:0] d);
        logic acc;
        int budget;
        budget = 200;
        i_valid = 1'b1;
        i_data  = d;
        do begin
            acc = i_rdy;
            tick();
            budget--;
        end while (!acc && budget > 0);
        if (!acc) chk("push_timeout", 0, 1);
        i_valid = 1'b0;
    endtask

    task automatic drain();
        int budget;
        budget = 200;
        o_rdy = 1'b1;
        while ((sb_q.size() != 0 || o_valid) && budget > 0) begin
            tick();
            budget--;
        end
        if (budget == 0) chk("drain_timeout", 0, 1);
    endtask

    initial begin
        int wr0;
        // Reset with i_valid asserted and downstream ready.
        nrst    = 1'b0;
        i_valid = 1'b1;
        i_data  = 32'hDEAD;
        o_rdy   = 1'b1;
        tick();
        for (int c = 0; c < 2; c++) begin
            chk("rst_o_valid", o_valid, 0);
            chk("rst_o_data",  o_data,  0);
            chk("rst_i_rdy",   i_rdy,   1);
            chk("rst_o_full",  o_full,  0);
            chk("rst_o_wr_en", o_wr_en, 0);
            tick();
        end
        i_valid = 1'b0;
        nrst    = 1'b1;
        tick();

        // Streaming at full rate.
        o_rdy = 1'b1;
        wr0 = n_wr;
        for (int k = 1; k <= 8; k++) begin
            push_word(DW'(k));
            chk("stream_i_rdy", i_rdy, 1);
        end
        drain();
        chk("stream_count", n_wr - wr0, 8);

        // Backpressure: fill, offer a third word, then release.
        o_rdy = 1'b0;
        push_word(32'hA);
        push_word(32'hB);
        chk("bp_i_rdy", i_rdy, 0);
        chk("bp_o_full", o_full, 1);
        i_valid = 1'b1;
        i_data  = 32'hC;
        repeat (3) begin
            tick();
            chk("bp_hold", o_data, 32'hA);
        end
        fork
            begin
                while (!i_rdy) tick();
                tick();
                i_valid = 1'b0;
            end
            begin
                tick();
                o_rdy = 1'b1;
            end
        join
        drain();

        // Random words with alternating downstream stalls.
        fork
            begin
                for (int k = 0; k < 16; k++) push_word($urandom());
            end
            begin
                for (int c = 0; c < 40; c++) begin
                    o_rdy = c[0];
                    tick();
                end
            end
        join
        drain();

        // Reset while full; the next push must be the first output.
        o_rdy = 1'b0;
        push_word(32'h5);
        push_word(32'h6);
        chk("mid_full", o_full, 1);
        nrst = 1'b0;
        tick();
        nrst = 1'b1;
        chk("mid_o_valid", o_valid, 0);
        chk("mid_i_rdy", i_rdy, 1);
        push_word(32'h7);
        chk("mid_first", o_data, 32'h7);
        drain();

`ifdef VXE_SKID_BUF_FLUSH_EN
        o_rdy = 1'b0;
        push_word(32'h11);
        push_word(32'h22);
        chk("fl_full", o_full, 1);
        i_valid = 1'b1;
        i_data  = 32'h33;
        o_rdy   = 1'b1;
        flush   = 1'b1;
        #1;
        chk("fl_wr_en", o_wr_en, 1);
        chk("fl_data", o_data, 32'h11);
        tick();
        flush   = 1'b0;
        i_valid = 1'b0;
        chk("fl_o_valid", o_valid, 0);
        chk("fl_i_rdy", i_rdy, 1);
        push_word(32'h44);
        chk("fl_next", o_data, 32'h44);
        drain();
`endif

        repeat (2) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
